// File: rtl/seg_display_scan.sv
// seg_display_scan: binary-to-BCD double-dabble converter feeding a multiplexed
// common-anode 7-segment scanner with leading-zero blanking, per-digit blink,
// overflow dashes and a raw-glyph text mode.
// Ports: clk_500Hz/rst (async, active-high); value/load/busy conversion handshake;
//        text_mode/glyphs/lz_blank/blink_mask display controls; seg/an registered
//        active-low outputs (digit 0 = leftmost = an[0]).
module seg_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int BLINK_HALF = 125
) (
  input  logic                    clk_500Hz,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  output logic                    busy,
  input  logic                    text_mode,
  input  logic [7*NUM_DIGITS-1:0] glyphs,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int BW  = 4 * NUM_DIGITS;
  localparam int CW  = $clog2(VALUE_W + 1);
  localparam int KW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value that fits in NUM_DIGITS decimal digits.
  localparam logic [63:0] MAX_DEC = pow10(NUM_DIGITS) - 64'd1;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return SEG_OFF;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Double-dabble converter
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nx;
  logic [VALUE_W-1:0] shreg, shreg_nx;
  logic [BW-1:0]      bcd, bcd_nx, bcd_adj;
  logic [BW-1:0]      disp, disp_nx;
  logic               ovf_pend, ovf_pend_nx;
  logic               ovf, ovf_nx;
  logic [CW-1:0]      cnt, cnt_nx;

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      disp     <= '0;
      ovf_pend <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bcd      <= bcd_nx;
      disp     <= disp_nx;
      ovf_pend <= ovf_pend_nx;
      ovf      <= ovf_nx;
      cnt      <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bcd_nx      = bcd;
    disp_nx     = disp;
    ovf_pend_nx = ovf_pend;
    ovf_nx      = ovf;
    cnt_nx      = cnt;
    bcd_adj     = bcd;

    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (bcd[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
    end

    case (state)
      IDLE: begin
        if (load) begin
          shreg_nx    = value;
          bcd_nx      = '0;
          ovf_pend_nx = (64'(value) > MAX_DEC);
          cnt_nx      = CW'(VALUE_W);
          state_nx    = SHIFT;
        end
      end
      SHIFT: begin
        // The top bit of the adjusted BCD falls off; overflow is tracked by ovf_pend.
        {bcd_nx, shreg_nx} = {bcd_adj[BW-2:0], shreg, 1'b0};
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          disp_nx  = bcd_nx;
          ovf_nx   = ovf_pend;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  // ---------------------------------------------------------------------------
  // Blink timebase and digit scanner
  // ---------------------------------------------------------------------------
  logic [KW-1:0]         k;
  logic [BCW-1:0]        bcnt;
  logic                  phase;      // 1 = visible half of the blink period
  logic                  zero_run;
  logic [6:0]            glyph_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_nx;

  always_comb begin
    zero_run = 1'b1;
    an_nx    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      // disp holds the most significant digit in its top nibble.
      zero_run = zero_run & (disp[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (blink_mask[i] && !phase)
        glyph_arr[i] = SEG_OFF;
      else if (text_mode)
        glyph_arr[i] = glyphs[7*i +: 7];
      else if (ovf)
        glyph_arr[i] = SEG_DASH;
      else if (lz_blank && (i < NUM_DIGITS - 1) && zero_run)
        glyph_arr[i] = SEG_OFF;
      else
        glyph_arr[i] = decode(disp[4*(NUM_DIGITS-1-i) +: 4]);
      an_nx[i] = (k != KW'(i));
    end
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      k     <= '0;
      an    <= '1;
      seg   <= SEG_OFF;
      bcnt  <= '0;
      phase <= 1'b1;
    end else begin
      an  <= an_nx;
      seg <= glyph_arr[k];
      k   <= (k == KW'(NUM_DIGITS - 1)) ? '0 : k + KW'(1);
      if (bcnt == BCW'(BLINK_HALF - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + BCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: self-checking bench for seg_display_scan (4 digits,
// 14-bit value, blink half-period of 4 edges).
// Drives loads from a vector table and scores scanned an/seg slots against a queue.
module tb_seg_display_scan;

  localparam int N  = 4;
  localparam int VW = 14;
  localparam int BH = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0011000, BL = 7'b1111111, DS = 7'b0111111;
  localparam logic [6:0] GE = 7'b0000110, GA = 7'b0001000, GS = 7'b0010010,
                         GY = 7'b0011001;

  logic            clk_500Hz = 1'b0;
  logic            rst, load, busy, text_mode, lz_blank;
  logic [VW-1:0]   value;
  logic [7*N-1:0]  glyphs;
  logic [N-1:0]    blink_mask;
  logic [6:0]      seg;
  logic [N-1:0]    an;

  seg_display_scan #(.NUM_DIGITS(N), .VALUE_W(VW), .BLINK_HALF(BH)) dut (
    .clk_500Hz(clk_500Hz), .rst(rst), .value(value), .load(load), .busy(busy),
    .text_mode(text_mode), .glyphs(glyphs), .lz_blank(lz_blank),
    .blink_mask(blink_mask), .seg(seg), .an(an)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  int checks = 0;
  int errors = 0;
  int ecount;  // edges since reset release

  always @(posedge clk_500Hz or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;
  slot_t sb[$];

  typedef struct {
    logic [VW-1:0] v;
    logic          lz;
    logic [6:0]    e0, e1, e2, e3;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] e0, e1, e2, e3);
    sb.push_back({4'b1110, e0});
    sb.push_back({4'b1101, e1});
    sb.push_back({4'b1011, e2});
    sb.push_back({4'b0111, e3});
  endtask

  // Load v, optionally pulse load again with mid_v at busy-cycle mid; returns busy length.
  task automatic do_load(input logic [VW-1:0] v, input int mid, input logic [VW-1:0] mid_v,
                         output int n);
    @(negedge clk_500Hz);
    value = v;
    load  = 1'b1;
    @(negedge clk_500Hz);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == mid) begin
        value = mid_v;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk_500Hz);
    end
    load = 1'b0;
  endtask

  // Align to digit 0 and compare one full scan against the scoreboard.
  task automatic scan_check(input string name);
    int n;
    slot_t e;
    n = 0;
    @(negedge clk_500Hz);
    while (an !== 4'b1110 && n < 20) begin
      @(negedge clk_500Hz);
      n++;
    end
    if (n >= 20) begin
      check({name, "_sync"}, an, 4'b1110);
      sb.delete();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (sb.size() == 0) begin
        check({name, "_sb_empty"}, sb.size(), N - i);
        return;
      end
      e = sb.pop_front();
      check($sformatf("%s_an%0d", name, i), an, e.an);
      check($sformatf("%s_seg%0d", name, i), seg, e.seg);
      @(negedge clk_500Hz);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{14'd1234,  1'b0, G1, G2, G3, G4};
    vecs[1] = '{14'd7,     1'b1, BL, BL, BL, G7};
    vecs[2] = '{14'd0,     1'b1, BL, BL, BL, G0};
    vecs[3] = '{14'd10000, 1'b0, DS, DS, DS, DS};
    vecs[4] = '{14'd9999,  1'b0, G9, G9, G9, G9};
    vecs[5] = '{14'd0,     1'b0, G0, G0, G0, G0};
    vecs[6] = '{14'd5678,  1'b0, G5, G6, G7, G8};
    vecs[7] = '{14'd1050,  1'b1, G1, G0, G5, G0};
    vecs[8] = '{14'd16383, 1'b1, DS, DS, DS, DS};
    vecs[9] = '{14'd42,    1'b1, BL, BL, G4, G2};

    rst = 1'b1; load = 1'b0; value = '0; text_mode = 1'b0;
    glyphs = '0; lz_blank = 1'b0; blink_mask = '0;

    // Reset state
    #3;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, BL);
    check("rst_busy", busy, 0);
    @(negedge clk_500Hz);
    @(negedge clk_500Hz);
    rst = 1'b0;
    @(negedge clk_500Hz);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, G0);

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      lz_blank = vecs[i].lz;
      push_exp(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      do_load(vecs[i].v, 0, '0, n);
      check($sformatf("busy_len_v%0d", i), n, 14);
      scan_check($sformatf("vec%0d", i));
    end

    // Text mode, conversion continues underneath
    lz_blank  = 1'b0;
    glyphs    = {GY, GS, GA, GE};
    text_mode = 1'b1;
    push_exp(GE, GA, GS, GY);
    do_load(14'd1234, 0, '0, n);
    check("busy_len_text", n, 14);
    scan_check("text");
    text_mode = 1'b0;
    push_exp(G1, G2, G3, G4);
    scan_check("text_off");

    // Blink digit 0; phase modelled from edges since reset
    blink_mask = 4'b0001;
    @(negedge clk_500Hz);
    for (int s = 0; s < 4; s++) begin
      n = 0;
      while (an !== 4'b1110 && n < 20) begin
        @(negedge clk_500Hz);
        n++;
      end
      if (n >= 20) check("blink_sync", an, 4'b1110);
      check($sformatf("blink_d0_s%0d", s), seg,
            (((ecount - 1) / BH) % 2 == 1) ? BL : G1);
      @(negedge clk_500Hz);
      check($sformatf("blink_d1_s%0d", s), seg, G2);
      @(negedge clk_500Hz);
      check($sformatf("blink_d2_s%0d", s), seg, G3);
      @(negedge clk_500Hz);
      check($sformatf("blink_d3_s%0d", s), seg, G4);
      @(negedge clk_500Hz);
    end
    blink_mask = '0;

    // Second load mid-conversion is ignored
    push_exp(G5, G6, G7, G8);
    do_load(14'd5678, 5, 14'd9999, n);
    check("busy_len_midload", n, 14);
    @(negedge clk_500Hz);
    check("no_retrigger", busy, 0);
    scan_check("midload");

    // Reset mid-conversion
    lz_blank = 1'b1;
    @(negedge clk_500Hz);
    value = 14'd4321;
    load  = 1'b1;
    @(negedge clk_500Hz);
    load = 1'b0;
    repeat (6) @(negedge clk_500Hz);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_an", an, 4'b1111);
    check("midrst_seg", seg, BL);
    check("midrst_busy", busy, 0);
    @(negedge clk_500Hz);
    rst = 1'b0;
    push_exp(BL, BL, BL, G0);
    scan_check("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Parametrised multiplexed 7-segment driver for the reaction-game display path. It converts a binary value to BCD sequentially using a double-dabble FSM, with a load/busy handshake. It then scans NUM_DIGITS common-anode digits at clk_500Hz, with optional leading-zero blanking, per-digit blinking, overflow indication and a raw-glyph text mode for mode names and messages.

## Interface
- NUM_DIGITS, 4: digits driven, legal range 1..8.
- VALUE_W, 14: width of the binary input value.
- BLINK_HALF, 125: clk_500Hz cycles per blink half-period (125 gives 2 Hz blink).

- clk_500Hz  in  1  scan/conversion clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- value  in  VALUE_W  unsigned binary number to display.
- load  in  1  capture value and start conversion; ignored while busy.
- busy  out  1  conversion in progress.
- text_mode  in  1  1 = show glyphs, 0 = show converted number.
- glyphs  in  7*NUM_DIGITS  active-low raw segments; digit i at [7i+6:7i].
- lz_blank  in  1  enable leading-zero blanking.
- blink_mask  in  NUM_DIGITS  bit i = digit i blinks.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low, registered.
- an  out  NUM_DIGITS  anodes, active low, one-hot-low, registered.

## Operation
- Digit 0 is leftmost / most significant and is driven by an[0]; digit NUM_DIGITS-1 is least significant.
- Converter FSM has two states, IDLE and SHIFT.
  - IDLE, load=1: capture value into the shift register, clear bcd (4*NUM_DIGITS bits), set ovf_pend = (value > 10^NUM_DIGITS - 1), load cnt = VALUE_W, go to SHIFT, busy=1.
  - SHIFT, each edge: add 3 to every bcd nibble >= 5, then shift {bcd, shreg} left by 1 and decrement cnt. Bits shifted out of the top of bcd are discarded.
  - On the edge where cnt reaches 0: copy bcd to disp, ovf_pend to ovf, go to IDLE, busy=0. The update of disp and ovf is atomic in that edge.
  - load while busy is ignored, with no queueing. load held high re-triggers one edge after busy falls.
- Scanner: scan counter k runs 0..NUM_DIGITS-1, increments every edge and wraps to 0. On each edge, an <= all ones except bit k low, and seg <= glyph(k).
- glyph(i) is resolved in priority order:
  1. blink_mask[i] and phase=off: 1111111.
  2. text_mode: glyphs[7i+6:7i].
  3. ovf: 0111111 (dash).
  4. lz_blank, i < NUM_DIGITS-1, and disp digits 0..i all zero: 1111111.
  5. Otherwise decode disp nibble i: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, other=1111111.
- The least-significant digit is never zero-blanked, so a value of 0 shows a single "0".
- Blink: counter 0..BLINK_HALF-1, free-running. phase toggles on each wrap and starts in the on (visible) state.
- Text mode does not stall conversion. disp keeps updating underneath and appears when text_mode drops.

## Timing
- Reset values:
  - an = all ones (all digits off), seg = 1111111, busy = 0.
  - disp = 0, ovf = 0, FSM = IDLE.
  - scan k = 0, blink counter = 0, phase = on.
- First digit is lit on the first edge after rst deasserts.
- Conversion latency: load sampled at edge E0, busy high after E0, disp valid after edge E0+VALUE_W (busy low after that same edge). First scan slot showing the new value comes at edge E0+VALUE_W+1.
- Scan period is NUM_DIGITS edges. Each anode is low for exactly 1 edge-period per scan. There is never more than one anode low.
- text_mode, glyphs, lz_blank and blink_mask are sampled every edge and affect the next registered seg only. No glitch within a slot.
- rst mid-conversion aborts: busy=0 and disp=0 immediately (asynchronous).
- Boundaries:
  - value = 10^NUM_DIGITS - 1 displays normally.
  - value = 10^NUM_DIGITS displays all dashes.
  - If 2^VALUE_W - 1 < 10^NUM_DIGITS, ovf never sets.
  - NUM_DIGITS=1: k stays 0 and an[0] stays low after reset.

## Test plan
- Defaults, load value=1234: busy high for exactly 14 edges. Then scan gives an 1110/1101/1011/0111 with seg 1111001/0100100/0110000/0011001.
- lz_blank=1, value=7: digits 0-2 show 1111111 and digit 3 shows 1111000. value=0 shows 1111111 ×3, then 1000000.
- value=10000 (fits 14 bits): all four digits show 0111111. A following load of 9999 shows 0011000 on every digit.
- text_mode=1, glyphs = E/A/S/Y (0000110, 0001000, 0010010, 0011001) in digits 0..3: exact glyphs appear in that order. load during text mode still completes and busy falls after 14 edges.
- blink_mask=0001 with BLINK_HALF=4: digit 0 alternates glyph / 1111111 every 4 edges, other digits stay steady.
- load pulsed again at mid-conversion edge 5: ignored, and the first result is unchanged. rst asserted at edge 7 of a conversion: an=1111, seg=1111111, busy=0, and after release digit 3 shows 0.
